// File: rtl/program_flow_unit.sv
`default_nettype none
// ============================================================================
//  Module      : program_flow_unit
//  Description : Owns the PC. Resolves relative branches from status flags,
//                moves status to and from GP registers, and runs trap
//                entry/return. Optional macro PF_BRANCH_STATS_EN adds a
//                saturating taken-branch counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module program_flow_unit #(
    parameter int                 ADDR_W   = 20,
    parameter int                 STAT_W   = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter logic [ADDR_W-1:0]  TRAP_VEC = 'h00010
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [3:0]        opcode,
    input  logic [ADDR_W-1:0] rel_addr,
    input  logic [STAT_W-1:0] status_in,
    input  logic [STAT_W-1:0] gp_in,
    input  logic              trap_req,
    output logic [ADDR_W-1:0] pc,
    output logic              branch_taken,
    output logic [STAT_W-1:0] gp_out,
    output logic              gp_we,
    output logic [STAT_W-1:0] status_out,
    output logic              status_we,
    output logic              in_trap,
    output logic [ADDR_W-1:0] saved_pc
`ifdef PF_BRANCH_STATS_EN
    ,
    output logic [15:0]       taken_count
`endif
);

    localparam logic [3:0] c_op_nop   = 4'd0;
    localparam logic [3:0] c_op_jmp   = 4'd1;
    localparam logic [3:0] c_op_jmpz  = 4'd2;
    localparam logic [3:0] c_op_jmps  = 4'd3;
    localparam logic [3:0] c_op_jmpzs = 4'd4;
    localparam logic [3:0] c_op_lstat = 4'd5;
    localparam logic [3:0] c_op_xstat = 4'd6;
    localparam logic [3:0] c_op_trap  = 4'd7;
    localparam logic [3:0] c_op_rtt   = 4'd8;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_ENTER = 2'd1,
        ST_EXIT  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   saved_pc_q, saved_pc_d;
    logic [STAT_W-1:0]   saved_status_q, saved_status_d;
    logic [STAT_W-1:0]   gp_out_q, gp_out_d;
    logic [STAT_W-1:0]   status_out_q, status_out_d;
    logic                in_trap_q, in_trap_d;
    logic                branch_taken_q, branch_taken_d;
    logic                gp_we_q, gp_we_d;
    logic                status_we_q, status_we_d;

    logic                w_trap_req_eff;
    logic                w_accept;
    logic                w_taken;
    logic                w_enter;
    logic [ADDR_W-1:0]   w_enter_pc;
    logic [ADDR_W-1:0]   w_pc_inc;
    logic [ADDR_W-1:0]   w_pc_rel;

    // An external request only matters outside trap mode; it blocks decode.
    assign w_trap_req_eff = trap_req && !in_trap_q;
    assign instr_ready    = (state_q == ST_RUN) && !w_trap_req_eff;
    assign w_accept       = instr_valid && instr_ready;
    assign w_pc_inc       = pc_q + ADDR_W'(1);
    assign w_pc_rel       = pc_q + rel_addr;

    always_comb begin
        state_d        = ST_RUN;
        pc_d           = pc_q;
        saved_pc_d     = saved_pc_q;
        saved_status_d = saved_status_q;
        gp_out_d       = gp_out_q;
        status_out_d   = status_out_q;
        in_trap_d      = in_trap_q;
        branch_taken_d = 1'b0;
        gp_we_d        = 1'b0;
        status_we_d    = 1'b0;
        w_taken        = 1'b0;
        w_enter        = 1'b0;
        w_enter_pc     = pc_q;

        if (state_q == ST_RUN) begin
            if (w_trap_req_eff) begin
                w_enter    = 1'b1;
                w_enter_pc = pc_q;
            end else if (w_accept) begin
                pc_d = w_pc_inc;
                case (opcode)
                    c_op_nop: ;
                    c_op_jmp:   w_taken = 1'b1;
                    c_op_jmpz:  w_taken = status_in[0];
                    c_op_jmps:  w_taken = status_in[1];
                    c_op_jmpzs: w_taken = status_in[0] && status_in[1];
                    c_op_lstat: begin
                        gp_out_d = status_in;
                        gp_we_d  = 1'b1;
                    end
                    c_op_xstat: begin
                        if (in_trap_q) begin
                            status_out_d = status_in ^ gp_in;
                            status_we_d  = 1'b1;
                        end
                    end
                    c_op_rtt: begin
                        if (in_trap_q) begin
                            pc_d         = saved_pc_q;
                            status_out_d = saved_status_q;
                            status_we_d  = 1'b1;
                            in_trap_d    = 1'b0;
                            state_d      = ST_EXIT;
                        end
                    end
                    // TRAP and every illegal opcode; inside a trap they are NOPs.
                    default: begin
                        if (!in_trap_q) begin
                            w_enter    = 1'b1;
                            w_enter_pc = w_pc_inc;
                        end
                    end
                endcase

                if (w_taken) begin
                    pc_d           = w_pc_rel;
                    branch_taken_d = 1'b1;
                end
            end

            if (w_enter) begin
                saved_pc_d     = w_enter_pc;
                saved_status_d = status_in;
                pc_d           = TRAP_VEC;
                in_trap_d      = 1'b1;
                state_d        = ST_ENTER;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= ST_RUN;
            pc_q           <= RESET_PC;
            saved_pc_q     <= '0;
            saved_status_q <= '0;
            gp_out_q       <= '0;
            status_out_q   <= '0;
            in_trap_q      <= 1'b0;
            branch_taken_q <= 1'b0;
            gp_we_q        <= 1'b0;
            status_we_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            saved_pc_q     <= saved_pc_d;
            saved_status_q <= saved_status_d;
            gp_out_q       <= gp_out_d;
            status_out_q   <= status_out_d;
            in_trap_q      <= in_trap_d;
            branch_taken_q <= branch_taken_d;
            gp_we_q        <= gp_we_d;
            status_we_q    <= status_we_d;
        end
    end

    assign pc           = pc_q;
    assign branch_taken = branch_taken_q;
    assign gp_out       = gp_out_q;
    assign gp_we        = gp_we_q;
    assign status_out   = status_out_q;
    assign status_we    = status_we_q;
    assign in_trap      = in_trap_q;
    assign saved_pc     = saved_pc_q;

`ifdef PF_BRANCH_STATS_EN
    logic [15:0] taken_count_q, taken_count_d;

    always_comb begin
        taken_count_d = taken_count_q;
        if (branch_taken_d && (taken_count_q != 16'hFFFF)) begin
            taken_count_d = taken_count_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            taken_count_q <= 16'd0;
        end else begin
            taken_count_q <= taken_count_d;
        end
    end

    assign taken_count = taken_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_program_flow_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_program_flow_unit
//  Description : Directed and randomized stimulus for program_flow_unit,
//                checked against a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_program_flow_unit;

    localparam logic [19:0] c_trap_vec = 20'h00010;

    logic        clock;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  opcode;
    logic [19:0] rel_addr;
    logic [3:0]  status_in;
    logic [3:0]  gp_in;
    logic        trap_req;
    logic [19:0] pc;
    logic        branch_taken;
    logic [3:0]  gp_out;
    logic        gp_we;
    logic [3:0]  status_out;
    logic        status_we;
    logic        in_trap;
    logic [19:0] saved_pc;
`ifdef PF_BRANCH_STATS_EN
    logic [15:0] taken_count;
`endif

    program_flow_unit dut (
        .clock        (clock),
        .reset        (reset),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .opcode       (opcode),
        .rel_addr     (rel_addr),
        .status_in    (status_in),
        .gp_in        (gp_in),
        .trap_req     (trap_req),
        .pc           (pc),
        .branch_taken (branch_taken),
        .gp_out       (gp_out),
        .gp_we        (gp_we),
        .status_out   (status_out),
        .status_we    (status_we),
        .in_trap      (in_trap),
        .saved_pc     (saved_pc)
`ifdef PF_BRANCH_STATS_EN
        ,
        .taken_count  (taken_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: architectural state plus a flag for the one dead cycle
    // that follows every trap entry or return.
    logic [19:0] m_pc, m_saved_pc;
    logic [3:0]  m_saved_st, m_gp_out, m_status_out;
    logic        m_in_trap, m_busy;
    logic        e_bt, e_gpwe, e_stwe;
    int          m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic v, input logic [3:0] op,
                              input logic [19:0] rel, input logic [3:0] st,
                              input logic [3:0] gp, input logic trq);
        logic taken, enters;
        e_bt = 1'b0; e_gpwe = 1'b0; e_stwe = 1'b0;
        taken  = (op == 4'd1) || (op == 4'd2 && st[0]) || (op == 4'd3 && st[1])
              || (op == 4'd4 && st[0] && st[1]);
        enters = !m_in_trap && (op == 4'd7 || op > 4'd8);
        if (r) begin
            m_pc = 20'd0; m_saved_pc = 20'd0; m_saved_st = 4'd0;
            m_gp_out = 4'd0; m_status_out = 4'd0; m_in_trap = 1'b0;
            m_busy = 1'b0; m_cnt = 0;
        end else if (m_busy) begin
            m_busy = 1'b0;
        end else if (trq && !m_in_trap) begin
            m_saved_pc = m_pc; m_saved_st = st;
            m_pc = c_trap_vec; m_in_trap = 1'b1; m_busy = 1'b1;
        end else if (v) begin
            if (taken) begin
                m_pc = m_pc + rel;
                e_bt = 1'b1;
                if (m_cnt < 65535) m_cnt++;
            end else if (enters) begin
                m_saved_pc = m_pc + 20'd1; m_saved_st = st;
                m_pc = c_trap_vec; m_in_trap = 1'b1; m_busy = 1'b1;
            end else if (op == 4'd8 && m_in_trap) begin
                m_pc = m_saved_pc; m_status_out = m_saved_st; e_stwe = 1'b1;
                m_in_trap = 1'b0; m_busy = 1'b1;
            end else begin
                m_pc = m_pc + 20'd1;
                if (op == 4'd5) begin m_gp_out = st; e_gpwe = 1'b1; end
                if (op == 4'd6 && m_in_trap) begin
                    m_status_out = st ^ gp; e_stwe = 1'b1;
                end
            end
        end
    endtask

    // One clock: drive after the falling edge, check ready before the rising
    // edge, check registered outputs 1 ns after it.
    task automatic cyc(input logic r, input logic v, input logic [3:0] op,
                       input logic [19:0] rel, input logic [3:0] st,
                       input logic [3:0] gp, input logic trq);
        reset = r; instr_valid = v; opcode = op; rel_addr = rel;
        status_in = st; gp_in = gp; trap_req = trq;
        #1;
        chk("instr_ready", 32'(instr_ready), 32'(!m_busy && !(trq && !m_in_trap)));
        @(posedge clock);
        model_step(r, v, op, rel, st, gp, trq);
        #1;
        chk("pc", 32'(pc), 32'(m_pc));
        chk("branch_taken", 32'(branch_taken), 32'(e_bt));
        chk("gp_out", 32'(gp_out), 32'(m_gp_out));
        chk("gp_we", 32'(gp_we), 32'(e_gpwe));
        chk("status_out", 32'(status_out), 32'(m_status_out));
        chk("status_we", 32'(status_we), 32'(e_stwe));
        chk("in_trap", 32'(in_trap), 32'(m_in_trap));
        chk("saved_pc", 32'(saved_pc), 32'(m_saved_pc));
`ifdef PF_BRANCH_STATS_EN
        chk("taken_count", 32'(taken_count), 32'(m_cnt));
`endif
        @(negedge clock);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 4'd0, 20'd0, 4'd0, 4'd0, 1'b0);
    endtask

    initial begin
        logic [3:0]  r_op;
        logic [19:0] r_rel;
        m_pc = 'x; m_saved_pc = 'x; m_saved_st = 'x; m_gp_out = 'x;
        m_status_out = 'x; m_in_trap = 1'b0; m_busy = 1'b0; m_cnt = 0;
        reset = 1'b1; instr_valid = 1'b0; opcode = 4'd0; rel_addr = 20'd0;
        status_in = 4'd0; gp_in = 4'd0; trap_req = 1'b0;
        @(negedge clock);

        // Reset and NOP stepping
        cyc(1'b1, 1'b0, 4'd0, 20'd0, 4'd0, 4'd0, 1'b0);
        cyc(1'b1, 1'b0, 4'd0, 20'd0, 4'd0, 4'd0, 1'b0);
        chk("reset_pc", 32'(pc), 32'h0);
        chk("reset_in_trap", 32'(in_trap), 32'h0);
        repeat (3) cyc(1'b0, 1'b1, 4'd0, 20'd0, 4'd0, 4'd0, 1'b0);
        chk("nop_pc", 32'(pc), 32'h3);
        idle();
        chk("idle_hold_pc", 32'(pc), 32'h3);

        // Backward JMP and wrap
        cyc(1'b0, 1'b1, 4'd1, 20'd2, 4'd0, 4'd0, 1'b0);
        chk("jmp_fwd_pc", 32'(pc), 32'h5);
        cyc(1'b0, 1'b1, 4'd1, 20'hFFFFD, 4'd0, 4'd0, 1'b0);
        chk("jmp_back_pc", 32'(pc), 32'h2);
        chk("jmp_back_taken", 32'(branch_taken), 32'h1);
        cyc(1'b0, 1'b1, 4'd1, 20'hFFFFE, 4'd0, 4'd0, 1'b0);
        cyc(1'b0, 1'b1, 4'd1, 20'hFFFFF, 4'd0, 4'd0, 1'b0);
        chk("pc_top", 32'(pc), 32'hFFFFF);
        cyc(1'b0, 1'b1, 4'd0, 20'd0, 4'd0, 4'd0, 1'b0);
        chk("pc_wrap", 32'(pc), 32'h0);

        // Conditional branches
        cyc(1'b0, 1'b1, 4'd2, 20'd8, 4'b0001, 4'd0, 1'b0);
        chk("jmpz_taken", 32'(pc), 32'h8);
        cyc(1'b0, 1'b1, 4'd3, 20'd8, 4'b0001, 4'd0, 1'b0);
        chk("jmps_not_taken", 32'(pc), 32'h9);
        chk("jmps_no_pulse", 32'(branch_taken), 32'h0);
        cyc(1'b0, 1'b1, 4'd4, 20'd8, 4'b0001, 4'd0, 1'b0);
        chk("jmpzs_not_taken", 32'(pc), 32'hA);
        cyc(1'b0, 1'b1, 4'd4, 20'd8, 4'b0011, 4'd0, 1'b0);
        chk("jmpzs_taken", 32'(pc), 32'h12);
        cyc(1'b0, 1'b1, 4'd1, 20'hFFFF5, 4'd0, 4'd0, 1'b0);
        chk("pc_seven", 32'(pc), 32'h7);

        // trap_req beats a valid instruction
        cyc(1'b0, 1'b1, 4'd0, 20'd0, 4'b1010, 4'd0, 1'b1);
        chk("trq_saved_pc", 32'(saved_pc), 32'h7);
        chk("trq_in_trap", 32'(in_trap), 32'h1);
        chk("trq_vec", 32'(pc), 32'h10);
        idle();
        cyc(1'b0, 1'b1, 4'd6, 20'd0, 4'b1010, 4'b0110, 1'b1);
        chk("xstat_value", 32'(status_out), 32'hC);
        chk("xstat_we", 32'(status_we), 32'h1);
        cyc(1'b0, 1'b1, 4'd8, 20'd0, 4'b0000, 4'd0, 1'b0);
        chk("rtt_pc", 32'(pc), 32'h7);
        chk("rtt_status", 32'(status_out), 32'hA);
        chk("rtt_in_trap", 32'(in_trap), 32'h0);
        idle();

        // Illegal opcode, then reset during ENTER
        cyc(1'b0, 1'b1, 4'd1, 20'hFFFFC, 4'd0, 4'd0, 1'b0);
        cyc(1'b0, 1'b1, 4'hC, 20'd0, 4'd0, 4'd0, 1'b0);
        chk("illegal_saved_pc", 32'(saved_pc), 32'h4);
        chk("illegal_vec", 32'(pc), 32'h10);
        cyc(1'b1, 1'b0, 4'd0, 20'd0, 4'd0, 4'd0, 1'b0);
        chk("abort_pc", 32'(pc), 32'h0);
        chk("abort_in_trap", 32'(in_trap), 32'h0);
        chk("abort_strobes", 32'({branch_taken, gp_we, status_we}), 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            r_op  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15))
                                                : 4'($urandom_range(0, 8));
            r_rel = ($urandom_range(0, 3) == 0) ? 20'($urandom)
                                                : 20'($signed($urandom_range(0, 64)) - 32);
            cyc(($urandom_range(0, 79) == 0), ($urandom_range(0, 3) != 0), r_op, r_rel,
                4'($urandom), 4'($urandom), ($urandom_range(0, 15) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
